// File: rtl/pipe_elastic_reg.sv
// Elastic pipeline register: DEPTH-entry circular buffer with valid/ready
// handshakes on both sides and a synchronous flush that outranks push/pop.
module pipe_elastic_reg #(
    parameter int unsigned       DATA_W     = 64,
    parameter int unsigned       DEPTH      = 2,
    parameter logic [DATA_W-1:0] RESET_DATA = '0
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         flush,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [DATA_W-1:0]            in_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [DATA_W-1:0]            out_data,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              push, pop;

    // Handshake status is decoded from the occupancy register only
    assign in_ready  = (count_q != CNT_W'(DEPTH));
    assign out_valid = (count_q != CNT_W'(0));
    assign out_data  = out_valid ? mem_q[rd_ptr_q] : RESET_DATA;
    assign count     = count_q;

    assign push = in_valid & in_ready & ~flush;
    assign pop  = out_valid & out_ready & ~flush;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            // Power-of-two depth lets the pointers wrap by natural overflow
            if (push) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            if (push && !pop) begin
                count_d = count_q + CNT_W'(1);
            end else if (pop && !push) begin
                count_d = count_q - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Payload storage is not reset; stale entries are masked by out_valid
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= in_data;
        end
    end

endmodule

// File: tb/tb_pipe_elastic_reg.sv
// Bench for pipe_elastic_reg: DEPTH=2 and DEPTH=4 instances share stimulus and
// are each checked against a queue-based reference model every cycle.
module tb_pipe_elastic_reg;

    localparam int unsigned DW   = 16;
    localparam logic [DW-1:0] RDATA = 16'hDEAD;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          flush;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          out_ready;

    logic          in_ready2, out_valid2, in_ready4, out_valid4;
    logic [DW-1:0] out_data2, out_data4;
    logic [1:0]    count2;
    logic [2:0]    count4;

    int unsigned tests = 0;
    int unsigned fails = 0;

    logic [DW-1:0] q2[$];
    logic [DW-1:0] q4[$];

    always #5 clk = ~clk;

    pipe_elastic_reg #(.DATA_W(DW), .DEPTH(2), .RESET_DATA(RDATA)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready2), .in_data(in_data),
        .out_valid(out_valid2), .out_ready(out_ready), .out_data(out_data2),
        .count(count2)
    );

    pipe_elastic_reg #(.DATA_W(DW), .DEPTH(4), .RESET_DATA(RDATA)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready4), .in_data(in_data),
        .out_valid(out_valid4), .out_ready(out_ready), .out_data(out_data4),
        .count(count4)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".d2.count"}, 64'(count2), 64'(q2.size()));
        chk({tag, ".d2.out_valid"}, 64'(out_valid2), 64'(q2.size() != 0));
        chk({tag, ".d2.in_ready"}, 64'(in_ready2), 64'(q2.size() < 2));
        chk({tag, ".d2.out_data"}, 64'(out_data2), 64'((q2.size() != 0) ? q2[0] : RDATA));
        chk({tag, ".d4.count"}, 64'(count4), 64'(q4.size()));
        chk({tag, ".d4.out_valid"}, 64'(out_valid4), 64'(q4.size() != 0));
        chk({tag, ".d4.in_ready"}, 64'(in_ready4), 64'(q4.size() < 4));
        chk({tag, ".d4.out_data"}, 64'(out_data4), 64'((q4.size() != 0) ? q4[0] : RDATA));
    endtask

    // Drive one cycle of stimulus at the falling edge, advance the model, check
    task automatic step(input string tag, input logic v, input logic [DW-1:0] d,
                        input logic r, input logic f);
        bit push2, pop2, push4, pop4;
        in_valid  = v;
        in_data   = d;
        out_ready = r;
        flush     = f;
        push2 = v && (q2.size() < 2);
        pop2  = r && (q2.size() != 0);
        push4 = v && (q4.size() < 4);
        pop4  = r && (q4.size() != 0);
        @(posedge clk);
        if (f) begin
            q2.delete();
            q4.delete();
        end else begin
            if (pop2)  void'(q2.pop_front());
            if (push2) q2.push_back(d);
            if (pop4)  void'(q4.pop_front());
            if (push4) q4.push_back(d);
        end
        @(negedge clk);
        check_all(tag);
    endtask

    initial begin
        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        check_all("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // Asynchronous reset mid-stream with two entries held
        step("pre_rst0", 1'b1, 16'h0001, 1'b0, 1'b0);
        step("pre_rst1", 1'b1, 16'h0002, 1'b0, 1'b0);
        chk("pre_rst.count", 64'(count2), 64'd2);
        #2 rst_n = 1'b0;
        #1;
        q2.delete();
        q4.delete();
        chk("async_rst.out_valid", 64'(out_valid2), 64'd0);
        chk("async_rst.in_ready", 64'(in_ready2), 64'd1);
        chk("async_rst.count", 64'(count2), 64'd0);
        chk("async_rst.out_data", 64'(out_data2), 64'(RDATA));
        check_all("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        step("post_rst_push", 1'b1, 16'h00A5, 1'b0, 1'b0);
        chk("post_rst.out_data", 64'(out_data2), 64'h00A5);
        step("post_rst_drain", 1'b0, 16'h0000, 1'b1, 1'b0);

        // Fill and backpressure
        step("fill0", 1'b1, 16'h0011, 1'b0, 1'b0);
        step("fill1", 1'b1, 16'h0022, 1'b0, 1'b0);
        chk("full.in_ready", 64'(in_ready2), 64'd0);
        step("full_hold", 1'b1, 16'h0033, 1'b0, 1'b0);
        chk("full.out_data", 64'(out_data2), 64'h0011);
        step("drain0", 1'b1, 16'h0033, 1'b1, 1'b0);
        chk("drain0.out_data", 64'(out_data2), 64'h0022);
        step("drain1", 1'b1, 16'h0033, 1'b1, 1'b0);
        step("drain2", 1'b0, 16'h0000, 1'b1, 1'b0);
        step("drain3", 1'b0, 16'h0000, 1'b1, 1'b0);
        step("drain4", 1'b0, 16'h0000, 1'b1, 1'b0);

        // Streaming at full throughput
        for (int i = 0; i < 16; i++) begin
            step("stream", 1'b1, DW'(i), 1'b1, 1'b0);
            chk("stream.count2", 64'(count2), 64'd1);
            chk("stream.data2", 64'(out_data2), 64'(i));
        end
        step("stream_end", 1'b0, 16'h0000, 1'b1, 1'b0);

        // Wrap-around with interleaved pops
        for (int i = 0; i < 6; i++) begin
            step("wrap_push", 1'b1, DW'(16'h0100 + i), 1'b0, 1'b0);
            if (i % 2 == 1) step("wrap_pop", 1'b0, 16'h0000, 1'b1, 1'b0);
        end
        for (int i = 0; i < 4; i++) step("wrap_drain", 1'b0, 16'h0000, 1'b1, 1'b0);

        // Flush outranks simultaneous push and pop
        step("fl_fill0", 1'b1, 16'h0044, 1'b0, 1'b0);
        step("fl_fill1", 1'b1, 16'h0055, 1'b0, 1'b0);
        step("flush", 1'b1, 16'h0077, 1'b1, 1'b1);
        chk("flush.count", 64'(count2), 64'd0);
        chk("flush.out_data", 64'(out_data2), 64'(RDATA));
        step("post_flush", 1'b0, 16'h0000, 1'b1, 1'b0);

        // Simultaneous push/pop at count=1
        step("pp_seed", 1'b1, 16'h0088, 1'b0, 1'b0);
        step("pp", 1'b1, 16'h0099, 1'b1, 1'b0);
        chk("pp.count", 64'(count2), 64'd1);
        chk("pp.out_data", 64'(out_data2), 64'h0099);

        // Randomised traffic
        for (int i = 0; i < 400; i++) begin
            step("rand", 1'($urandom_range(0, 1)), DW'($urandom),
                 1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 31) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/pipe_elastic_reg.md
# pipe_elastic_reg

Parametrised elastic pipeline register that generalises the fixed IF/ID-style stage register. It carries a DATA_W-bit payload (e.g. {pc, instruction}) through a DEPTH-entry circular buffer with valid/ready handshakes on both sides and a synchronous flush. It sits between any two pipeline stages. Downstream stalls and upstream branch flushes are absorbed without losing or duplicating entries.

## Interface
- DATA_W, 64: payload width in bits (>=1).
- DEPTH, 2: number of buffer entries; power of two, >=2.
- RESET_DATA, {DATA_W{1'b0}}: value driven on out_data whenever out_valid=0.
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- flush  input  1  synchronous; discards all stored entries.
- in_valid  input  1  upstream offers in_data.
- in_ready  output  1  buffer can accept an entry this cycle.
- in_data  input  DATA_W  upstream payload.
- out_valid  output  1  head entry is present.
- out_ready  input  1  downstream accepts the head entry.
- out_data  output  DATA_W  head entry payload.
- count  output  $clog2(DEPTH+1)  number of stored entries, 0..DEPTH.

## Operation
- State:
  - storage array mem[DEPTH];
  - wr_ptr and rd_ptr, each $clog2(DEPTH) bits;
  - count register.
- Definitions:
  - push = in_valid & in_ready
  - pop = out_valid & out_ready
- in_ready = (count != DEPTH), decoded from registers only. There is no combinational path from out_ready or in_valid to in_ready, so a full buffer refuses a push even when a pop occurs in the same cycle.
- out_valid = (count != 0).
- out_data = mem[rd_ptr] when out_valid=1, otherwise RESET_DATA. It is decoded from registers only.
- On push: mem[wr_ptr] <= in_data; wr_ptr increments modulo DEPTH (DEPTH-1 wraps to 0).
- On pop: rd_ptr increments modulo DEPTH.
- count update:
  - push only: +1
  - pop only: -1
  - push and pop together: unchanged
  - neither: unchanged
- Flush (highest priority):
  - count, wr_ptr and rd_ptr all go to 0.
  - A push or pop presented in the same cycle is ignored: the entry is not written and the pop does not advance.
  - mem contents are not cleared; they are masked by out_valid=0.
- Empty: out_ready is ignored, and no state changes except via push.
- Full: in_valid is ignored and in_data is not sampled; the upstream stage stalls.
- Ordering is strict FIFO. Every accepted entry is delivered exactly once unless flushed.
- Reset (asynchronous, any time including mid-transfer):
  - count=0, wr_ptr=0, rd_ptr=0;
  - therefore in_ready=1, out_valid=0, out_data=RESET_DATA.
  - mem is not reset.
  - Operation resumes on the first rising edge after rst_n deasserts.

## Timing
- Latency: an entry pushed at edge N is visible on out_data/out_valid after edge N, i.e. in cycle N+1. Minimum latency is 1 cycle.
- Throughput: 1 entry/cycle sustained when out_ready=1 continuously, for any DEPTH>=2.
- Output stability: while out_valid=1 and out_ready=0, out_data holds constant until pop, flush or reset.
- in_ready, out_valid, out_data and count are all registered or decoded from registers, with no input-to-output combinational paths.
- After flush at edge N: out_valid=0 and in_ready=1 from cycle N+1. A push is accepted again in cycle N+1.

## Test plan
- Reset/idle:
  - Drive rst_n=0 mid-stream with count=2.
  - Required immediately (asynchronous), without a clock edge: out_valid=0, in_ready=1, count=0, out_data=RESET_DATA.
  - After release, push 0xA5: out_data=0xA5 one cycle later.
- Fill and backpressure (DEPTH=2, out_ready=0):
  - Push 0x11, then 0x22.
  - Required: in_ready=0 from the cycle after the second push; a third in_valid with 0x33 is not accepted; out_data holds 0x11.
  - Raise out_ready: deliver 0x11, then 0x22; 0x33 is accepted only once in_ready=1.
- Streaming:
  - in_valid=out_ready=1 for 16 cycles with incrementing data 0..15.
  - Required: out_data sequence 0..15 with no gaps after 1-cycle latency; count stays 1.
- Wrap-around (DEPTH=4):
  - Push 6 entries with interleaved pops.
  - Required: wr_ptr and rd_ptr wrap 3->0; output order matches input order; count never exceeds 4.
- Flush priority:
  - With count=2, assert flush together with in_valid=1 (data 0x77) and out_ready=1.
  - Required: next cycle count=0, out_valid=0, out_data=RESET_DATA; 0x77 never appears on the output.
- Simultaneous push/pop at count=1:
  - Required: count stays 1, and out_data changes to the newly pushed value on the next cycle.
